// File: rtl/dm_if.sv
// Request/response bundle between a load/store requester and the dm_responder memory.
interface dm_if;
   logic        req;
   logic        we;
   logic        mem_byte;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (
      output req, we, mem_byte, addr, wdata,
      input  rdata, ready, err, busy
   );

   modport slave (
      input  req, we, mem_byte, addr, wdata,
      output rdata, ready, err, busy
   );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: wait-stated word/byte load/store into an internal word array.
// state     | meaning
// ST_IDLE   | waiting for req; captures the request
// ST_WAIT   | inserting WAIT_CYCLES wait states
// ST_ACCESS | memory read or (read-modify-)write
// ST_RESP   | one-cycle ready pulse with err/rdata
module dm_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_LOG2  = 10
) (
   input logic clk,
   input logic rst,
   dm_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t state, state_nx;

   logic [3:0]  cnt_r;
   logic        we_r;
   logic        byte_r;
   logic        err_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [31:0] rdata_r;

   logic [31:0] mem [2**DEPTH_LOG2];

   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0] rd_word;
   logic [31:0] wr_word;
   logic [7:0]  rd_lane;
   logic        misalign;
   logic        mem_we;
   logic        unused_addr;

   assign misalign    = !bus.mem_byte && (bus.addr[1:0] != 2'b00);
   assign idx         = addr_r[DEPTH_LOG2+1:2];
   assign rd_word     = mem[idx];
   // Address bits above the array wrap silently
   assign unused_addr = ^addr_r[31:DEPTH_LOG2+2];

   always_comb begin
      rd_lane = rd_word[7:0];
      wr_word = rd_word;
      case (addr_r[1:0])
         2'd0: begin rd_lane = rd_word[7:0];   wr_word[7:0]   = wdata_r[7:0]; end
         2'd1: begin rd_lane = rd_word[15:8];  wr_word[15:8]  = wdata_r[7:0]; end
         2'd2: begin rd_lane = rd_word[23:16]; wr_word[23:16] = wdata_r[7:0]; end
         default: begin rd_lane = rd_word[31:24]; wr_word[31:24] = wdata_r[7:0]; end
      endcase
      if (!byte_r) wr_word = wdata_r;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (bus.req) begin
               if (misalign)             state_nx = ST_RESP;
               else if (WAIT_CYCLES > 0) state_nx = ST_WAIT;
               else                      state_nx = ST_ACCESS;
            end
         end
         ST_WAIT:   if (cnt_r == 4'd0) state_nx = ST_ACCESS;
         ST_ACCESS: state_nx = ST_RESP;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= 4'd0;
         we_r    <= 1'b0;
         byte_r  <= 1'b0;
         err_r   <= 1'b0;
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         rdata_r <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  we_r    <= bus.we;
                  byte_r  <= bus.mem_byte;
                  addr_r  <= bus.addr;
                  wdata_r <= bus.wdata;
                  err_r   <= misalign;
                  cnt_r   <= WAIT_LOAD;
                  if (misalign) rdata_r <= 32'd0;
               end
            end
            ST_WAIT: cnt_r <= cnt_r - 4'd1;
            ST_ACCESS: begin
               if (we_r)        rdata_r <= 32'd0;
               else if (byte_r) rdata_r <= {{24{rd_lane[7]}}, rd_lane};
               else             rdata_r <= rd_word;
            end
            default: ;
         endcase
      end
   end

   // Memory is never reset; a reset landing on ACCESS cancels the write
   assign mem_we = (state == ST_ACCESS) && we_r && !rst;

   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wr_word;
   end

   assign bus.ready = !rst && (state == ST_RESP);
   assign bus.err   = bus.ready && err_r;
   assign bus.busy  = !rst && (state != ST_IDLE);
   assign bus.rdata = rst ? 32'd0 : rdata_r;
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder against an array-based memory model.
module tb_dm_responder;
   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dm_if bus ();
   dm_if bus2 ();

   dm_responder #(.WAIT_CYCLES(W), .DEPTH_LOG2(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   dm_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(10)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [31:0] model [1024];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] a, input bit b);
      logic [31:0] w;
      logic [7:0]  l;
      w = model[a[11:2]];
      l = w[8*a[1:0] +: 8];
      return b ? {{24{l[7]}}, l} : w;
   endfunction

   task automatic model_store(input logic [31:0] a, input bit b, input logic [31:0] d);
      if (b) model[a[11:2]][8*a[1:0] +: 8] = d[7:0];
      else   model[a[11:2]] = d;
   endtask

   task automatic access(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                         input string tag, output logic [31:0] rd);
      bit          mis;
      int          exp_lat;
      logic [31:0] exp_rd;
      int          lat;
      logic [31:0] held;
      mis     = !b && (a[1:0] != 2'b00);
      exp_lat = mis ? 1 : W + 2;
      exp_rd  = (w || mis) ? 32'd0 : model_load(a, b);
      @(negedge clk);
      bus.req = 1'b1; bus.we = w; bus.mem_byte = b; bus.addr = a; bus.wdata = d;
      @(posedge clk); #1;
      // scramble inputs: the DUT must work from its captured copies
      bus.req = 1'b0; bus.we = 1'($urandom); bus.mem_byte = 1'($urandom);
      bus.addr = $urandom; bus.wdata = $urandom;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      lat = 1;
      while (!bus.ready && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(bus.err), 32'(mis));
      check({tag, "_rdata"}, bus.rdata, exp_rd);
      rd   = bus.rdata;
      held = bus.rdata;
      if (w && !mis) model_store(a, b, d);
      @(posedge clk); #1;
      check({tag, "_rdy_off"}, 32'(bus.ready), 32'd0);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_hold"}, bus.rdata, held);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] old;
      logic [7:0]  exp_rdy;
      logic [7:0]  exp_busy;
      int          pulses;

      bus.req = 1'b0; bus.we = 1'b0; bus.mem_byte = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.mem_byte = 1'b0; bus2.addr = 32'd0; bus2.wdata = 32'd0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom, "init", rd);

      access(1'b1, 1'b0, 32'h10, 32'h12345678, "w10", rd);
      access(1'b0, 1'b0, 32'h10, 32'h0, "r10", rd);
      check("r10_val", rd, 32'h12345678);

      access(1'b1, 1'b1, 32'h11, 32'h000000AA, "sb11", rd);
      access(1'b1, 1'b1, 32'h13, 32'hFFFFFF80, "sb13", rd);
      access(1'b0, 1'b0, 32'h10, 32'h0, "lw10", rd);
      check("lw10_val", rd, 32'h8034AA78);
      access(1'b0, 1'b1, 32'h13, 32'h0, "lb13", rd);
      check("lb13_val", rd, 32'hFFFFFF80);
      access(1'b0, 1'b1, 32'h11, 32'h0, "lb11", rd);
      check("lb11_val", rd, 32'hFFFFFFAA);

      old = model[1];
      access(1'b1, 1'b0, 32'h6, 32'hCAFEF00D, "mis6", rd);
      access(1'b0, 1'b0, 32'h4, 32'h0, "r4", rd);
      check("r4_unchanged", rd, old);

      access(1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, "wrap_w", rd);
      access(1'b0, 1'b0, 32'h0, 32'h0, "wrap_r", rd);
      check("wrap_val", rd, 32'hDEADBEEF);

      // reset during WAIT: access aborted, memory untouched
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.mem_byte = 1'b0; bus.addr = 32'h20; bus.wdata = ~model[8];
      @(posedge clk); #1;
      bus.req = 1'b0;
      check("abw_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abw_busy_off", 32'(bus.busy), 32'd0);
      check("abw_ready", 32'(bus.ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 2) begin
         @(posedge clk); #1;
         check("abw_no_pulse", 32'(bus.ready), 32'd0);
      end
      access(1'b0, 1'b0, 32'h20, 32'h0, "abw_rd", rd);

      // reset during ACCESS: write suppressed
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.mem_byte = 1'b0; bus.addr = 32'h24; bus.wdata = ~model[9];
      @(posedge clk); #1;
      bus.req = 1'b0;
      repeat (W) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("aba_busy_off", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      access(1'b0, 1'b0, 32'h24, 32'h0, "aba_rd", rd);

      repeat (60) begin
         access(1'($urandom), 1'($urandom), $urandom & 32'hFFFFF03F, $urandom, "rnd", rd);
      end

      // zero wait states, req held high for six cycles
      exp_rdy  = 8'b0001_0010;
      exp_busy = 8'b0001_1011;
      pulses   = 0;
      @(negedge clk);
      bus2.req = 1'b1; bus2.we = 1'b1; bus2.mem_byte = 1'b0; bus2.addr = 32'h0; bus2.wdata = 32'h55;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (k == 6) bus2.req = 1'b0;
         pulses += int'(bus2.ready);
         check("w0_ready", 32'(bus2.ready), 32'(exp_rdy[k-1]));
         check("w0_busy", 32'(bus2.busy), 32'(exp_busy[k-1]));
      end
      check("w0_pulses", 32'(pulses), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
